// File: rtl/shift_counter.sv
// One-hot ping-pong shift counter: a single set bit walks LSB->MSB->LSB forever.
// Optional build macro SHIFT_COUNTER_RECOVER_EN adds one-cycle illegal-state recovery.
module shift_counter #(
   parameter int unsigned WIDTH = 8
) (
   output logic [WIDTH-1:0] count,
   input  logic             clk,
   input  logic             reset
);

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   dir_t             dir;
   dir_t             next_dir;
   logic [WIDTH-1:0] next_count;

   always_comb begin
      next_count = count;
      next_dir   = dir;
      if (dir == UP) begin
         next_count = count << 1;
         if (next_count[WIDTH-1]) next_dir = DOWN;
      end else begin
         next_count = count >> 1;
         if (next_count[0]) next_dir = UP;
      end
   end

`ifdef SHIFT_COUNTER_RECOVER_EN
   localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

   logic illegal;

   // Not one-hot, or sitting on an end with the direction already pointing off it.
   always_comb begin
      illegal = 1'b0;
      if (count == '0)                              illegal = 1'b1;
      if ((count & (count - LSB_ONE)) != '0)        illegal = 1'b1;
      if ((count == MSB_ONE) && (dir == UP))        illegal = 1'b1;
      if ((count == LSB_ONE) && (dir == DOWN))      illegal = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset || illegal) begin
         count <= {{(WIDTH-1){1'b0}}, 1'b1};
         dir   <= UP;
      end else begin
         count <= next_count;
         dir   <= next_dir;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= {{(WIDTH-1){1'b0}}, 1'b1};
         dir   <= UP;
      end else begin
         count <= next_count;
         dir   <= next_dir;
      end
   end
`endif

endmodule

// File: tb/tb_shift_counter.sv
// Directed bench for shift_counter at WIDTH = 8, 4 and 2 sharing one clock and reset.
`timescale 1ns/1ps
module tb_shift_counter;

   logic       clk;
   logic       reset;
   logic [7:0] count8;
   logic [3:0] count4;
   logic [1:0] count2;

   int unsigned total = 0;
   int unsigned bad   = 0;

   shift_counter #(.WIDTH(8)) dut8 (.count(count8), .clk(clk), .reset(reset));
   shift_counter #(.WIDTH(4)) dut4 (.count(count4), .clk(clk), .reset(reset));
   shift_counter #(.WIDTH(2)) dut2 (.count(count2), .clk(clk), .reset(reset));

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [7:0] seq8 [14];
   logic [3:0] seq4 [6];

   initial begin
      seq8 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
      seq4 = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};

      reset = 1'b0;
      #100 reset = 1'b1;
      #80;
      chk("reset8", count8, 8'h01);
      chk("reset4", count4, 4'h1);
      chk("reset2", count2, 2'h1);
      #20 reset = 1'b0;

      // 23 steps: one full period plus walk into the down leg to 8'h20.
      for (int i = 0; i < 23; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("seq8[%0d]", i), count8, seq8[i % 14]);
         chk($sformatf("onehot8[%0d]", i), $countones(count8), 1);
         chk($sformatf("seq4[%0d]", i), count4, seq4[i % 6]);
         chk($sformatf("seq2[%0d]", i), count2, (i % 2 == 0) ? 2'h2 : 2'h1);
      end
      chk("middown", count8, 8'h20);

      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("midrst", count8, 8'h01);
      @(posedge clk);
      #1 chk("midrst+1", count8, 8'h02);
      @(posedge clk);
      #1 chk("midrst+2", count8, 8'h04);

      // Reset pulse that never sees a rising edge must be ignored.
      #4 reset = 1'b1;
      #4 reset = 1'b0;
      @(posedge clk);
      #1 chk("glitch", count8, 8'h08);

`ifdef SHIFT_COUNTER_RECOVER_EN
      @(negedge clk);
      force dut8.count = 8'h06;
      #1 release dut8.count;
      @(posedge clk);
      #1 chk("recov06", count8, 8'h01);
      @(posedge clk);
      #1 chk("recov06+1", count8, 8'h02);
      @(negedge clk);
      force dut8.count = 8'h00;
      #1 release dut8.count;
      @(posedge clk);
      #1 chk("recov00", count8, 8'h01);
      @(posedge clk);
      #1 chk("recov00+1", count8, 8'h02);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
